// File: rtl/ifu.sv
// ---------------------------------------------------------------------------
// ifu -- instruction fetch unit for the multi-cycle NPC core.
//
// Holds the PC and fetches one instruction at a time. Only one instruction is
// ever in flight. The sequence for each instruction is:
//   1. Issue a request on the imem port.
//   2. Capture the response.
//   3. Present {pc, inst, fault} to decode until decode accepts it.
//   4. Wait for the next PC from write-back, then issue the next fetch.
//
// Optional feature (compile-time macro IFU_MISALIGN_CHECK_EN):
//   A PC with pc[1:0] != 0 is not sent to memory. It is handed to decode
//   directly as a fault with inst = 0.
//
// Parameters:
//   XLEN      address / instruction width (default 32)
//   RESET_PC  PC loaded on reset (default 32'h8000_0000)
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_req_valid/ready/addr     fetch request channel (addr == PC)
//   imem_rsp_valid/data/err       fetch response channel
//   id_valid/ready                decode handshake
//   id_pc/inst/fault              instruction presented to decode
//   npc_valid/npc                 next PC from write-back
//   fetch_cnt                     instructions accepted by decode (mod 2^64)
// ---------------------------------------------------------------------------
module ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,

    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic            id_fault,

    input  logic            npc_valid,
    input  logic [XLEN-1:0] npc,

    output logic [63:0]     fetch_cnt
);

    typedef enum logic [1:0] {
        S_REQ      = 2'd0,
        S_WAIT     = 2'd1,
        S_HOLD     = 2'd2,
        S_WAIT_NPC = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic            misaligned;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // The request is decoded straight from the state register so that it is
    // up in the very first cycle after reset. It is gated by rst so that
    // nothing is issued while reset is held.
    assign imem_req_valid = (state == S_REQ) && !misaligned && !rst;
    assign imem_req_addr  = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            id_valid  <= 1'b0;
            id_pc     <= RESET_PC;
            id_inst   <= '0;
            id_fault  <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            case (state)
                S_REQ: begin
                    if (misaligned) begin
                        // Skip memory entirely; decode sees a faulting slot.
                        id_valid <= 1'b1;
                        id_pc    <= pc;
                        id_inst  <= '0;
                        id_fault <= 1'b1;
                        state    <= S_HOLD;
                    end else if (imem_req_ready) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        id_valid <= 1'b1;
                        id_pc    <= pc;
                        id_inst  <= imem_rsp_err ? '0 : imem_rsp_data;
                        id_fault <= imem_rsp_err;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // The decode outputs are untouched here, so they stay
                    // stable under back-pressure.
                    if (id_ready) begin
                        id_valid  <= 1'b0;
                        fetch_cnt <= fetch_cnt + 64'd1;
                        state     <= S_WAIT_NPC;
                    end
                end
                S_WAIT_NPC: begin
                    if (npc_valid) begin
                        pc    <= npc;
                        state <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// ---------------------------------------------------------------------------
// tb_ifu -- self-checking bench for ifu.
//
// The reference model works at the transaction level. It tracks:
//   - the expected PC,
//   - the expected instruction count,
//   - the expected decode payload.
// The bench walks each fetch through its phases with randomized stalls and
// junk on ignored inputs.
// ---------------------------------------------------------------------------
module tb_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef IFU_MISALIGN_CHECK_EN
    localparam bit MIS_CHECK = 1'b1;
`else
    localparam bit MIS_CHECK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_fault;
    logic        npc_valid;
    logic [31:0] npc;
    logic [63:0] fetch_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] exp_pc;
    logic [31:0] exp_id_pc;
    logic [31:0] exp_inst;
    logic        exp_fault;
    logic [63:0] exp_cnt;

    ifu #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_fault       (id_fault),
        .npc_valid      (npc_valid),
        .npc            (npc),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_decode(input string tag);
        check({tag, "_id_pc"},    id_pc,     exp_id_pc);
        check({tag, "_id_inst"},  id_inst,   exp_inst);
        check({tag, "_id_fault"}, id_fault,  exp_fault);
        check({tag, "_cnt"},      fetch_cnt, exp_cnt);
    endtask

    task automatic check_reset_values();
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_id_valid",  id_valid,       1'b0);
        check("rst_id_pc",     id_pc,          RESET_PC);
        check("rst_id_inst",   id_inst,        32'h0);
        check("rst_id_fault",  id_fault,       1'b0);
        check("rst_cnt",       fetch_cnt,      64'h0);
    endtask

    task automatic model_reset();
        exp_pc    = RESET_PC;
        exp_id_pc = RESET_PC;
        exp_inst  = 32'h0;
        exp_fault = 1'b0;
        exp_cnt   = 64'h0;
    endtask

    // One complete instruction, starting with the DUT in REQ and ending with
    // it back in REQ at the new PC.
    task automatic fetch(input int req_stall, input int rsp_dly, input int hold_stall,
                         input bit spurious, input int npc_dly,
                         input logic [31:0] data, input bit err, input logic [31:0] nxt);
        logic [31:0] rsp_word;
        bit          mis;
        mis = MIS_CHECK && (exp_pc[1:0] != 2'b00);
        if (mis) begin
            check("mis_req_valid", imem_req_valid, 1'b0);
            imem_req_ready = 1'($urandom_range(0, 1));
            tick();
            imem_req_ready = 1'b0;
            exp_inst  = 32'h0;
            exp_fault = 1'b1;
        end else begin
            for (int i = 0; i < req_stall; i++) begin
                imem_req_ready = 1'b0;
                imem_rsp_valid = 1'($urandom_range(0, 1));
                imem_rsp_data  = $urandom;
                id_ready       = 1'($urandom_range(0, 1));
                npc_valid      = 1'($urandom_range(0, 1));
                npc            = $urandom;
                check("stall_req_valid", imem_req_valid, 1'b1);
                check("stall_req_addr",  imem_req_addr,  exp_pc);
                check("stall_id_valid",  id_valid,       1'b0);
                tick();
            end
            imem_rsp_valid = 1'b0;
            id_ready       = 1'b0;
            npc_valid      = 1'b0;
            imem_req_ready = 1'b1;
            check("req_valid", imem_req_valid, 1'b1);
            check("req_addr",  imem_req_addr,  exp_pc);
            tick();
            imem_req_ready = 1'b0;
            check("wait_req_valid", imem_req_valid, 1'b0);
            for (int i = 0; i < rsp_dly; i++) begin
                id_ready  = 1'($urandom_range(0, 1));
                npc_valid = 1'($urandom_range(0, 1));
                npc       = $urandom;
                tick();
                check("wait_id_valid",  id_valid,       1'b0);
                check("wait_req_valid", imem_req_valid, 1'b0);
            end
            id_ready       = 1'b0;
            npc_valid      = 1'b0;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = data;
            imem_rsp_err   = err;
            tick();
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
            imem_rsp_data  = $urandom;
            rsp_word  = err ? 32'h0 : data;
            exp_inst  = rsp_word;
            exp_fault = err;
        end
        exp_id_pc = exp_pc;
        check("hold_id_valid", id_valid, 1'b1);
        check_decode("hold");
        for (int i = 0; i < hold_stall; i++) begin
            id_ready = 1'b0;
            if (spurious && i == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hDEAD_BEEF;
                imem_rsp_err   = 1'($urandom_range(0, 1));
                npc_valid      = 1'b1;
                npc            = $urandom;
            end
            tick();
            imem_rsp_valid = 1'b0;
            imem_rsp_err   = 1'b0;
            npc_valid      = 1'b0;
            check("bp_id_valid", id_valid, 1'b1);
            check_decode("bp");
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
        exp_cnt  = exp_cnt + 64'd1;
        check("acc_id_valid", id_valid, 1'b0);
        check_decode("acc");
        for (int i = 0; i < npc_dly; i++) begin
            imem_rsp_valid = 1'($urandom_range(0, 1));
            imem_rsp_data  = $urandom;
            id_ready       = 1'($urandom_range(0, 1));
            tick();
            check("npc_req_valid", imem_req_valid, 1'b0);
            check_decode("npcw");
        end
        imem_rsp_valid = 1'b0;
        id_ready       = 1'b0;
        npc_valid      = 1'b1;
        npc            = nxt;
        tick();
        npc_valid = 1'b0;
        npc       = $urandom;
        exp_pc    = nxt;
    endtask

    initial begin
        logic [31:0] nxt;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_rsp_err   = 1'b0;
        id_ready       = 1'b0;
        npc_valid      = 1'b0;
        npc            = 32'h0;
        model_reset();
        tick();
        tick();
        check_reset_values();
        rst = 1'b0;
        #1;

        // Zero-wait memory, two back-to-back instructions
        fetch(0, 0, 0, 1'b0, 0, 32'h0000_0093, 1'b0, 32'h8000_0004);
        fetch(0, 0, 0, 1'b0, 0, 32'h0000_0113, 1'b0, 32'h8000_0008);

        // Request back-pressure for 5 cycles
        fetch(5, 1, 0, 1'b0, 1, 32'h1234_5678, 1'b0, 32'h8000_0010);

        // Decode back-pressure with a spurious response pulse
        fetch(0, 0, 3, 1'b1, 0, 32'h0040_0513, 1'b0, 32'h8000_0014);

        // Error response
        fetch(1, 2, 1, 1'b0, 2, 32'hFFFF_FFFF, 1'b1, 32'h8000_0018);

        // Reset while waiting for the response
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        model_reset();
        check_reset_values();
        rst = 1'b0;
        #1;
        fetch(0, 0, 0, 1'b0, 0, 32'h0000_0793, 1'b0, 32'h8000_0002);

        // Misaligned PC, then back to an aligned one
        fetch(0, 0, 0, 1'b0, 0, 32'h0000_0013, 1'b0, 32'h8000_0020);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            nxt = $urandom;
            if ($urandom_range(0, 3) != 0) nxt[1:0] = 2'b00;
            fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3),
                  $urandom, 1'($urandom_range(0, 4) == 0), nxt);
        end
        check("final_req_addr", imem_req_addr, exp_pc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the multi-cycle NPC core. Holds the PC, fetches one 32-bit instruction per retire through a valid/ready memory port, and hands `{pc, inst}` to the decode stage, whose opcode/funct key lookups build the control signals. It then waits for the next-PC from the write-back stage before fetching again. Exactly one instruction is in flight at any time.

## Interface

- `RESET_PC`, default 32'h8000_0000: PC loaded on reset.
- `XLEN`, default 32: address and instruction width.

Ports:

- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request.
- `imem_req_addr`  out  XLEN  fetch address; always equals the current PC.
- `imem_rsp_valid`  in  1  response valid.
- `imem_rsp_data`  in  XLEN  fetched instruction word.
- `imem_rsp_err`  in  1  access fault; sampled with `imem_rsp_valid`.
- `id_valid`  out  1  instruction presented to decode.
- `id_ready`  in  1  decode accepts the instruction.
- `id_pc`  out  XLEN  PC of the presented instruction.
- `id_inst`  out  XLEN  presented instruction.
- `id_fault`  out  1  presented instruction is faulting; `id_inst` is 0.
- `npc_valid`  in  1  next PC valid from write-back.
- `npc`  in  XLEN  next PC.
- `fetch_cnt`  out  64  count of instructions accepted by decode.

## Operation

- States: REQ, WAIT, HOLD, WAIT_NPC.
- REQ:
  - `imem_req_valid`=1.
  - On `imem_req_valid && imem_req_ready`, go to WAIT.
- WAIT:
  - `imem_req_valid`=0.
  - On `imem_rsp_valid`, register `id_inst` and `id_fault` and go to HOLD.
  - On an error response, `id_inst` is 0 and `id_fault` is 1.
  - With no error, `id_inst` is `imem_rsp_data` and `id_fault` is 0.
- HOLD:
  - `id_valid`=1.
  - `id_pc`, `id_inst` and `id_fault` stay stable until the handshake.
  - On `id_ready`, `fetch_cnt` increments by 1 and the state goes to WAIT_NPC.
- WAIT_NPC:
  - On `npc_valid`, the PC takes `npc` and the state goes to REQ.
- Outputs in other states:
  - `id_valid` is 0 outside HOLD.
  - `id_pc`, `id_inst` and `id_fault` keep their last registered values outside HOLD.
- Ignored inputs:
  - `imem_rsp_valid` outside WAIT is ignored.
  - `npc_valid` outside WAIT_NPC is ignored.
  - `id_ready` outside HOLD is ignored.
- `fetch_cnt` wraps modulo 2^64.
- `npc` is taken as-is. There is no alignment fixup unless the feature in Configuration is compiled in.

## Timing

- Reset values:
  - State is REQ and the PC is `RESET_PC`.
  - `imem_req_valid`=0 and `id_valid`=0.
  - `id_pc`=`RESET_PC`, `id_inst`=0, `id_fault`=0, `fetch_cnt`=0.
- `imem_req_valid` is a combinational decode of the state register. It is forced to 0 while `rst` is high.
  - First request: the first cycle after `rst` deasserts.
- `imem_req_addr` is driven from the PC register and stays stable while `imem_req_valid`=1 and `imem_req_ready`=0.
  - `imem_req_valid` never drops without a handshake.
- Minimum latency:
  - Request handshake in cycle N.
  - Response in N+1.
  - `id_valid` in N+2.
  - Decode handshake in N+2.
  - `npc_valid` in N+3.
  - Next request in N+4, i.e. 4 cycles per instruction.
- The memory must not return a response in the same cycle its request is accepted.
- Reset mid-operation, from any state:
  - Returns to the reset values on the next edge.
  - Any outstanding memory response is discarded.
  - The memory is reset by the same `rst`, so no late response arrives after reset.
- Back-pressure:
  - `id_ready`=0 holds HOLD indefinitely with no change on the decode outputs.
  - `imem_req_ready`=0 holds REQ indefinitely.

## Configuration

- `IFU_MISALIGN_CHECK_EN`, when defined:
  - In REQ with `pc[1:0]`≠0, no request is issued (`imem_req_valid`=0).
  - The next state is HOLD with `id_inst`=0, `id_fault`=1 and `id_pc`=PC.
  - The instruction is handed to decode as a fault.
- When undefined:
  - Misaligned PCs are fetched like any other, with `imem_req_addr`=PC unchanged.
  - `id_fault` is set only from `imem_rsp_err`.

## Test plan

- Reset then zero-wait memory (`req_ready`=1, response one cycle later with 32'h0000_0093), `id_ready`=1, `npc_valid`=1 with 32'h8000_0004 → request addr 32'h8000_0000; `id_valid` two cycles after the handshake with `id_inst`=32'h0000_0093, `id_pc`=32'h8000_0000; second request addr 32'h8000_0004; `fetch_cnt`=1 then 2.
- `imem_req_ready` held 0 for 5 cycles → `imem_req_valid`=1 and `imem_req_addr` stable for all 5 cycles; exactly one request handshake.
- `id_ready`=0 for 3 cycles in HOLD, plus a spurious `imem_rsp_valid` pulse with 32'hDEAD_BEEF → `id_inst` unchanged and `fetch_cnt` unchanged until `id_ready`=1.
- Response with `imem_rsp_err`=1 and data 32'hFFFF_FFFF → `id_fault`=1, `id_inst`=0.
- `rst` pulsed while in WAIT, then the memory responds normally → outputs return to reset values; the next request address is `RESET_PC`; `fetch_cnt`=0.
- `npc`=32'h8000_0002:
  - With `IFU_MISALIGN_CHECK_EN` → no request; `id_fault`=1, `id_pc`=32'h8000_0002.
  - Without it → request addr 32'h8000_0002.
